// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter
// FSM state encoding, default RAM wait and access timer width
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEM_RD,
      MEM_WR,
      IF_RD
   } arb_state_e;

   localparam int WAIT_CYCLES_DEF = 2;

   // counter must hold values 0..wait_c
   function automatic int tmr_w(input int wait_c);
      return (wait_c < 1) ? 1 : $clog2(wait_c + 1);
   endfunction

endpackage

// File: rtl/arb_access_timer.sv
// arb_access_timer: loadable down-counter timing a RAM read
// load/load_val preset, dec steps toward 0, zero flags expiry
module arb_access_timer
   import mem_arb_pkg::*;
#(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port RAM shared by fetch and MEM stage
// MEM (older) wins; stall_o freezes the pipe while a MEM access is open
//   in : mem_read/write/addr/wdata, if_req/addr, ram_rdata
//   out: ram_en/we/addr/wdata, mem_rdata/done, if_rdata/valid, stall
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-3:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_done_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   output logic              stall_o
);

   localparam int TW = tmr_w(WAIT_CYCLES);
   localparam logic [TW-1:0] LOAD_V = TW'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
   end

   arb_state_e st, st_nx;

   logic mem_req, mem_grant, if_grant;
   logic t_load, t_dec, t_zero;
   logic en_nx, we_nx, mdone_nx, ivalid_nx;
   logic [ADDR_W-3:0] addr_nx;
   logic [DATA_W-1:0] wdata_nx, mrdata_nx, irdata_nx;
   logic unused_lsb;

   assign mem_req = mem_read_i | mem_write_i;
   // done marks the request as stale: the pipe advances on that edge
   assign stall_o = mem_req & ~mem_done_o;
   assign unused_lsb = ^{mem_addr_i[1:0], if_addr_i[1:0]};

   arb_access_timer #(
      .W(TW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (t_load),
      .load_val(LOAD_V),
      .dec     (t_dec),
      .zero    (t_zero)
   );

   always_comb begin
      st_nx     = st;
      en_nx     = 1'b0;
      we_nx     = 1'b0;
      addr_nx   = ram_addr_o;
      wdata_nx  = ram_wdata_o;
      mrdata_nx = mem_rdata_o;
      irdata_nx = if_rdata_o;
      mdone_nx  = 1'b0;
      ivalid_nx = 1'b0;
      t_load    = 1'b0;
      t_dec     = 1'b0;
      mem_grant = 1'b0;
      if_grant  = 1'b0;

      unique case (st)
         IDLE: begin
            if (mem_req && !mem_done_o) begin
               mem_grant = 1'b1;
            end else if (if_req_i) begin
               if_grant = 1'b1;
            end
         end
         MEM_WR: begin
            mdone_nx = 1'b1;
            st_nx    = IDLE;
         end
         MEM_RD: begin
            if (t_zero) begin
               mrdata_nx = ram_rdata_i;
               mdone_nx  = 1'b1;
               st_nx     = IDLE;
            end else begin
               t_dec = 1'b1;
            end
         end
         IF_RD: begin
            if (t_zero) begin
               irdata_nx = ram_rdata_i;
               ivalid_nx = 1'b1;
               st_nx     = IDLE;
               // a waiting MEM access takes the port on the same edge
               mem_grant = mem_req;
            end else begin
               t_dec = 1'b1;
            end
         end
      endcase

      if (mem_grant) begin
         en_nx    = 1'b1;
         we_nx    = mem_write_i;
         addr_nx  = mem_addr_i[ADDR_W-1:2];
         wdata_nx = mem_wdata_i;
         t_load   = ~mem_write_i;
         st_nx    = mem_write_i ? MEM_WR : MEM_RD;
      end else if (if_grant) begin
         en_nx   = 1'b1;
         addr_nx = if_addr_i[ADDR_W-1:2];
         t_load  = 1'b1;
         st_nx   = IF_RD;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st          <= IDLE;
         ram_en_o    <= 1'b0;
         ram_we_o    <= 1'b0;
         ram_addr_o  <= '0;
         ram_wdata_o <= '0;
         mem_rdata_o <= '0;
         mem_done_o  <= 1'b0;
         if_rdata_o  <= '0;
         if_valid_o  <= 1'b0;
      end else begin
         st          <= st_nx;
         ram_en_o    <= en_nx;
         ram_we_o    <= we_nx;
         ram_addr_o  <= addr_nx;
         ram_wdata_o <= wdata_nx;
         mem_rdata_o <= mrdata_nx;
         mem_done_o  <= mdone_nx;
         if_rdata_o  <= irdata_nx;
         if_valid_o  <= ivalid_nx;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
// dut uses WAIT_CYCLES=2, dut1 uses WAIT_CYCLES=1
module tb_mem_port_arbiter;

   typedef struct {
      logic [31:0] data;
      logic        chk_data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        mem_read_i, mem_write_i, if_req_i;
   logic [31:0] mem_addr_i, mem_wdata_i, if_addr_i;
   logic        ram_en_o, ram_we_o, mem_done_o, if_valid_o, stall_o;
   logic [29:0] ram_addr_o;
   logic [31:0] ram_wdata_o, ram_rdata_i, mem_rdata_o, if_rdata_o;

   logic        mem_read1;
   logic [31:0] mem_addr1;
   logic        ram_en1, mem_done1, stall1;
   logic [29:0] ram_addr1;
   logic [31:0] ram_rdata1, mem_rdata1;
   logic        unused_we1, unused_valid1;
   logic [31:0] unused_wdata1, unused_irdata1;

   logic [31:0] ram [0:255];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int en0 = 0, dn0 = 0, en1 = 0, dn1 = 0;

   exp_t mq[$];
   exp_t iq[$];
   exp_t mq1[$];

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
      .ram_rdata_i(ram_rdata_i),
      .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
      .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
      .stall_o(stall_o)
   );

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)
   ) dut1 (
      .clk(clk), .rst(rst),
      .mem_read_i(mem_read1), .mem_write_i(1'b0),
      .mem_addr_i(mem_addr1), .mem_wdata_i(32'h0),
      .if_req_i(1'b0), .if_addr_i(32'h0),
      .ram_en_o(ram_en1), .ram_we_o(unused_we1),
      .ram_addr_o(ram_addr1), .ram_wdata_o(unused_wdata1),
      .ram_rdata_i(ram_rdata1),
      .mem_rdata_o(mem_rdata1), .mem_done_o(mem_done1),
      .if_rdata_o(unused_irdata1), .if_valid_o(unused_valid1),
      .stall_o(stall1)
   );

   // RAM model: write on enabled edge, read data follows held address
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'hA5A50000 | 32'(i);
         ram[8'h40] <= 32'h00500093;
         ram[8'h80] <= 32'hCAFE0001;
         ram[8'h50] <= 32'h0BADF00D;
         ram[8'h04] <= 32'h0;
      end else if (ram_en_o && ram_we_o) begin
         ram[ram_addr_o[7:0]] <= ram_wdata_o;
      end
   end
   assign ram_rdata_i = ram[ram_addr_o[7:0]];
   assign ram_rdata1  = ram[ram_addr1[7:0]];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: pops expectations whenever a completion pulse appears
   always @(negedge clk) begin : mon
      exp_t e;
      if (ram_en_o) en0 <= en0 + 1;
      if (mem_done_o) dn0 <= dn0 + 1;
      if (ram_en1) en1 <= en1 + 1;
      if (mem_done1) dn1 <= dn1 + 1;
      if (rst) begin
         if (mem_done_o) begin
            chk("mem_done_expected", 64'(mq.size() != 0), 64'd1);
            if (mq.size() != 0) begin
               e = mq.pop_front();
               chk("mem_done_cycle", 64'(cyc), 64'(e.cyc));
               if (e.chk_data)
                  chk("mem_rdata", 64'(mem_rdata_o), 64'(e.data));
            end
         end
         if (if_valid_o) begin
            chk("if_valid_expected", 64'(iq.size() != 0), 64'd1);
            if (iq.size() != 0) begin
               e = iq.pop_front();
               chk("if_valid_cycle", 64'(cyc), 64'(e.cyc));
               chk("if_rdata", 64'(if_rdata_o), 64'(e.data));
            end
         end
         if (mem_done1) begin
            chk("w1_done_expected", 64'(mq1.size() != 0), 64'd1);
            if (mq1.size() != 0) begin
               e = mq1.pop_front();
               chk("w1_done_cycle", 64'(cyc), 64'(e.cyc));
               chk("w1_rdata", 64'(mem_rdata1), 64'(e.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, e0, d0, e1, d1;
      rst = 1'b0;
      mem_read_i = 1'b0; mem_write_i = 1'b0; if_req_i = 1'b0;
      mem_addr_i = '0; mem_wdata_i = '0; if_addr_i = '0;
      mem_read1 = 1'b0; mem_addr1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flags", 64'({ram_en_o, ram_we_o, mem_done_o,
          if_valid_o, stall_o}), 64'd0);
      chk("rst_addr", 64'(ram_addr_o), 64'd0);
      chk("rst_wdata", 64'(ram_wdata_o), 64'd0);
      chk("rst_rdata", {mem_rdata_o, if_rdata_o}, 64'd0);
      rst = 1'b1;
      tick(); tick();

      // reset in the middle of a load
      mem_read_i = 1'b1; mem_addr_i = 32'h40;
      tick();
      chk("t1_grant_en", 64'(ram_en_o), 64'd1);
      chk("t1_grant_addr", 64'(ram_addr_o), 64'h10);
      #2;
      rst = 1'b0; mem_read_i = 1'b0; mem_addr_i = '0;
      #1;
      chk("t1_rst_flags", 64'({ram_en_o, ram_we_o, mem_done_o,
          if_valid_o, stall_o}), 64'd0);
      chk("t1_rst_addr", 64'(ram_addr_o), 64'd0);
      tick();
      rst = 1'b1;
      repeat (5) tick();

      // fetch only
      if_req_i = 1'b1; if_addr_i = 32'h100; n = cyc;
      iq.push_back('{data: 32'h00500093, chk_data: 1'b1, cyc: n + 3});
      #1 chk("t2_stall_req", 64'(stall_o), 64'd0);
      tick();
      chk("t2_en", 64'({ram_en_o, ram_we_o}), 64'b10);
      chk("t2_addr", 64'(ram_addr_o), 64'h40);
      if_req_i = 1'b0;
      tick();
      chk("t2_en_drop", 64'(ram_en_o), 64'd0);
      chk("t2_stall", 64'(stall_o), 64'd0);
      tick(); tick();

      // load with concurrent fetch: MEM wins, IF on done cycle
      mem_read_i = 1'b1; mem_addr_i = 32'h200;
      if_req_i = 1'b1; if_addr_i = 32'h100; n = cyc;
      mq.push_back('{data: 32'hCAFE0001, chk_data: 1'b1, cyc: n + 3});
      iq.push_back('{data: 32'h00500093, chk_data: 1'b1, cyc: n + 6});
      #1 chk("t3_stall_c0", 64'(stall_o), 64'd1);
      tick();
      chk("t3_mem_en", 64'({ram_en_o, ram_we_o}), 64'b10);
      chk("t3_mem_addr", 64'(ram_addr_o), 64'h80);
      chk("t3_stall_c1", 64'(stall_o), 64'd1);
      tick();
      chk("t3_stall_c2", 64'(stall_o), 64'd1);
      tick();
      chk("t3_stall_done", 64'(stall_o), 64'd0);
      tick();
      chk("t3_if_en", 64'(ram_en_o), 64'd1);
      chk("t3_if_addr", 64'(ram_addr_o), 64'h40);
      mem_read_i = 1'b0; if_req_i = 1'b0;
      repeat (4) tick();

      // store then readback
      mem_write_i = 1'b1; mem_addr_i = 32'h10;
      mem_wdata_i = 32'h1234ABCD; n = cyc;
      mq.push_back('{data: 32'h0, chk_data: 1'b0, cyc: n + 2});
      #1 chk("t4_stall", 64'(stall_o), 64'd1);
      tick();
      chk("t4_en_we", 64'({ram_en_o, ram_we_o}), 64'b11);
      chk("t4_addr", 64'(ram_addr_o), 64'h4);
      chk("t4_wdata", 64'(ram_wdata_o), 64'h1234ABCD);
      tick();
      chk("t4_done_en", 64'({ram_en_o, ram_we_o}), 64'd0);
      chk("t4_done_stall", 64'(stall_o), 64'd0);
      tick();
      chk("t4_no_regrant", 64'(ram_en_o), 64'd0);
      mem_write_i = 1'b0; mem_read_i = 1'b1; n = cyc;
      mq.push_back('{data: 32'h1234ABCD, chk_data: 1'b1, cyc: n + 3});
      tick();
      chk("t4_rd_addr", 64'(ram_addr_o), 64'h4);
      repeat (3) tick();
      mem_read_i = 1'b0;
      chk("t4_rd_no_regrant", 64'(ram_en_o), 64'd0);
      tick();

      // load arrives while a fetch is in flight
      if_req_i = 1'b1; if_addr_i = 32'h100; n = cyc;
      iq.push_back('{data: 32'h00500093, chk_data: 1'b1, cyc: n + 3});
      tick();
      chk("t5_if_addr", 64'(ram_addr_o), 64'h40);
      if_req_i = 1'b0; mem_read_i = 1'b1; mem_addr_i = 32'h140;
      mq.push_back('{data: 32'h0BADF00D, chk_data: 1'b1, cyc: n + 5});
      #1 chk("t5_stall_wait", 64'(stall_o), 64'd1);
      tick();
      chk("t5_stall_c2", 64'(stall_o), 64'd1);
      tick();
      chk("t5_mem_en", 64'({ram_en_o, ram_we_o}), 64'b10);
      chk("t5_mem_addr", 64'(ram_addr_o), 64'h50);
      tick();
      chk("t5_stall_c4", 64'(stall_o), 64'd1);
      tick();
      chk("t5_stall_done", 64'(stall_o), 64'd0);
      tick();
      mem_read_i = 1'b0;
      chk("t5_no_regrant", 64'(ram_en_o), 64'd0);
      tick();

      // load held over done cycle, both wait settings
      mem_read_i = 1'b1; mem_addr_i = 32'h200;
      mem_read1 = 1'b1; mem_addr1 = 32'h200; n = cyc;
      e0 = en0; d0 = dn0; e1 = en1; d1 = dn1;
      mq.push_back('{data: 32'hCAFE0001, chk_data: 1'b1, cyc: n + 3});
      mq1.push_back('{data: 32'hCAFE0001, chk_data: 1'b1, cyc: n + 2});
      #1 chk("t6_w1_stall", 64'(stall1), 64'd1);
      tick();
      chk("t6_w1_addr", 64'(ram_addr1), 64'h80);
      tick();
      chk("t6_w1_stall_done", 64'(stall1), 64'd0);
      tick();
      mem_read1 = 1'b0;
      chk("t6_stall_done", 64'(stall_o), 64'd0);
      tick();
      mem_read_i = 1'b0;
      repeat (3) tick();
      chk("t6_w2_accesses", 64'(en0 - e0), 64'd1);
      chk("t6_w2_dones", 64'(dn0 - d0), 64'd1);
      chk("t6_w1_accesses", 64'(en1 - e1), 64'd1);
      chk("t6_w1_dones", 64'(dn1 - d1), 64'd1);

      chk("mem_q_drained", 64'(mq.size()), 64'd0);
      chk("if_q_drained", 64'(iq.size()), 64'd0);
      chk("w1_q_drained", 64'(mq1.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
